// File: rtl/mlt3_line_decoder.sv
// MLT-3 receive stage: recovers NRZ bits from three-level line samples,
// tracks the encoder state, assembles words and flags long bit runs.
module mlt3_line_decoder #(
   parameter int WORD_W  = 8,
   parameter int RUN_MAX = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lvl_valid,
   input  logic [1:0]        lvl,
   output logic              bit_valid,
   output logic              bit_out,
   output logic              word_valid,
   output logic [WORD_W-1:0] word,
   output logic              code_err,
   output logic              run_flag,
   output logic [1:0]        mlt_state
);

   localparam int BW = $clog2(WORD_W + 1);
   localparam int RW = $clog2(RUN_MAX + 1);

   typedef enum logic [1:0] {
      ST_TOP    = 2'b00,
      ST_DOWN   = 2'b01,
      ST_BOTTOM = 2'b10,
      ST_UP     = 2'b11
   } mlt_st_e;

   mlt_st_e           state_q, state_d;
   logic              bit_valid_q, bit_valid_d;
   logic              bit_out_q, bit_out_d;
   logic              word_valid_q, word_valid_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              code_err_q, code_err_d;
   logic              run_flag_q, run_flag_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [RW-1:0]     run_cnt_q, run_cnt_d;
   logic              last_bit_q, last_bit_d;

   logic              legal;
   logic              dec_bit;
   mlt_st_e           nxt_st;

   // Any +/-1 sample pins the encoder to top/bottom, legal or not,
   // so resync falls out of the same decode.
   always_comb begin
      legal   = 1'b0;
      dec_bit = 1'b0;
      nxt_st  = state_q;
      unique case (lvl)
         2'b00: begin
            legal = 1'b1;
            unique case (state_q)
               ST_BOTTOM: begin
                  dec_bit = 1'b1;
                  nxt_st  = ST_UP;
               end
               ST_TOP: begin
                  dec_bit = 1'b1;
                  nxt_st  = ST_DOWN;
               end
               default: begin
                  dec_bit = 1'b0;
                  nxt_st  = state_q;
               end
            endcase
         end
         2'b10: begin
            nxt_st  = ST_BOTTOM;
            legal   = (state_q == ST_DOWN) || (state_q == ST_BOTTOM);
            dec_bit = (state_q == ST_DOWN);
         end
         2'b01: begin
            nxt_st  = ST_TOP;
            legal   = (state_q == ST_UP) || (state_q == ST_TOP);
            dec_bit = (state_q == ST_UP);
         end
         default: begin
            legal  = 1'b0;
            nxt_st = state_q;
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      bit_valid_d  = 1'b0;
      bit_out_d    = 1'b0;
      word_valid_d = 1'b0;
      word_d       = word_q;
      code_err_d   = 1'b0;
      run_flag_d   = run_flag_q;
      bit_cnt_d    = bit_cnt_q;
      run_cnt_d    = run_cnt_q;
      last_bit_d   = last_bit_q;
      if (lvl_valid) begin
         state_d = nxt_st;
         if (legal) begin
            bit_valid_d = 1'b1;
            bit_out_d   = dec_bit;
            word_d      = {word_q[WORD_W-2:0], dec_bit};
            if (bit_cnt_q == BW'(WORD_W - 1)) begin
               bit_cnt_d    = '0;
               word_valid_d = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
            // run_cnt_q == 0 means no previous bit to compare against
            if ((run_cnt_q != '0) && (dec_bit == last_bit_q)) begin
               if (run_cnt_q != RW'(RUN_MAX))
                  run_cnt_d = run_cnt_q + 1'b1;
            end else begin
               run_cnt_d = RW'(1);
            end
            last_bit_d = dec_bit;
            run_flag_d = (run_cnt_d >= RW'(RUN_MAX));
         end else begin
            code_err_d = 1'b1;
            bit_cnt_d  = '0;
            run_cnt_d  = '0;
            run_flag_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_DOWN;
         bit_valid_q  <= 1'b0;
         bit_out_q    <= 1'b0;
         word_valid_q <= 1'b0;
         word_q       <= '0;
         code_err_q   <= 1'b0;
         run_flag_q   <= 1'b0;
         bit_cnt_q    <= '0;
         run_cnt_q    <= '0;
         last_bit_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_valid_q  <= bit_valid_d;
         bit_out_q    <= bit_out_d;
         word_valid_q <= word_valid_d;
         word_q       <= word_d;
         code_err_q   <= code_err_d;
         run_flag_q   <= run_flag_d;
         bit_cnt_q    <= bit_cnt_d;
         run_cnt_q    <= run_cnt_d;
         last_bit_q   <= last_bit_d;
      end
   end

   assign bit_valid  = bit_valid_q;
   assign bit_out    = bit_out_q;
   assign word_valid = word_valid_q;
   assign word       = word_q;
   assign code_err   = code_err_q;
   assign run_flag   = run_flag_q;
   assign mlt_state  = state_q;

endmodule

// File: tb/tb_mlt3_line_decoder.sv
// Directed bench for mlt3_line_decoder: bit recovery, words,
// illegal codes, runs, gaps and mid-word reset.
module tb_mlt3_line_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       lvl_valid;
   logic [1:0] lvl;
   logic       bit_valid;
   logic       bit_out;
   logic       word_valid;
   logic [7:0] word;
   logic       code_err;
   logic       run_flag;
   logic [1:0] mlt_state;

   int total = 0;
   int bad   = 0;
   logic [1:0] enc_st;

   always #5 clk = ~clk;

   mlt3_line_decoder #(.WORD_W(8), .RUN_MAX(6)) dut (
      .clk(clk),
      .rst(rst),
      .lvl_valid(lvl_valid),
      .lvl(lvl),
      .bit_valid(bit_valid),
      .bit_out(bit_out),
      .word_valid(word_valid),
      .word(word),
      .code_err(code_err),
      .run_flag(run_flag),
      .mlt_state(mlt_state)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [1:0] l);
      @(negedge clk);
      rst = r;
      lvl_valid = v;
      lvl = l;
      @(posedge clk);
      #1;
   endtask

   // encoder model: top=00 down=01 bottom=10 up=11
   function automatic logic [1:0] enc_next(input logic [1:0] s);
      case (s)
         2'b00:   return 2'b01;
         2'b01:   return 2'b10;
         2'b10:   return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] enc_lvl(input logic [1:0] s);
      case (s)
         2'b00:   return 2'b01;
         2'b10:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   task automatic send_bit(input logic b);
      if (b) enc_st = enc_next(enc_st);
      step(1'b1, 1'b1, enc_lvl(enc_st));
      chk("bv", bit_valid, 1);
      chk("bit", bit_out, b);
      chk("st", mlt_state, enc_st);
      chk("err", code_err, 0);
   endtask

   task automatic gap();
      logic rf;
      rf = run_flag;
      step(1'b1, 1'b0, 2'b11);
      chk("gap_bv", bit_valid, 0);
      chk("gap_wv", word_valid, 0);
      chk("gap_err", code_err, 0);
      chk("gap_st", mlt_state, enc_st);
      chk("gap_rf", run_flag, rf);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic gaps);
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i]);
         chk("wv", word_valid, (i == 0));
         if (gaps && i != 0) gap();
      end
      chk("word", word, b);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b1, 2'b01);
      enc_st = 2'b01;
   endtask

   initial begin
      logic [1:0] lv [4];
      logic [1:0] st [4];
      rst = 1'b0;
      lvl_valid = 1'b1;
      lvl = 2'b01;
      enc_st = 2'b01;

      step(1'b0, 1'b1, 2'b01);
      step(1'b0, 1'b1, 2'b01);
      chk("rst_st", mlt_state, 2'b01);
      chk("rst_bv", bit_valid, 0);
      chk("rst_bit", bit_out, 0);
      chk("rst_wv", word_valid, 0);
      chk("rst_err", code_err, 0);
      chk("rst_rf", run_flag, 0);
      chk("rst_word", word, 0);

      lv = '{2'b10, 2'b00, 2'b01, 2'b00};
      st = '{2'b10, 2'b11, 2'b00, 2'b01};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, lv[i]);
         chk("seq_bv", bit_valid, 1);
         chk("seq_bit", bit_out, 1);
         chk("seq_st", mlt_state, st[i]);
      end
      enc_st = 2'b01;
      for (int i = 0; i < 4; i++) begin
         send_bit(1'b0);
         chk("f0_wv", word_valid, (i == 3));
      end
      chk("f0_word", word, 8'hF0);

      send_byte(8'hA5, 1'b0);

      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      step(1'b1, 1'b1, 2'b01);
      chk("ill_err", code_err, 1);
      chk("ill_bv", bit_valid, 0);
      chk("ill_st", mlt_state, 2'b00);
      chk("ill_rf", run_flag, 0);
      enc_st = 2'b00;
      send_byte(8'h3C, 1'b0);
      step(1'b1, 1'b1, 2'b11);
      chk("x11_err", code_err, 1);
      chk("x11_bv", bit_valid, 0);
      chk("x11_st", mlt_state, 2'b00);

      do_reset();
      chk("rst2_st", mlt_state, 2'b01);
      for (int i = 0; i < 6; i++) begin
         send_bit(1'b0);
         chk("run_rf", run_flag, (i == 5));
      end
      send_bit(1'b0);
      chk("run_sat", run_flag, 1);
      gap();
      send_bit(1'b1);
      chk("run_drop", run_flag, 0);

      do_reset();
      send_byte(8'hA5, 1'b1);

      do_reset();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      do_reset();
      chk("mid_wv", word_valid, 0);
      chk("mid_st", mlt_state, 2'b01);
      chk("mid_word", word, 0);
      send_byte(8'h96, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
